// File: rtl/fixed_div_seq_if.sv
// Operand/result handshake bundle for fixed_div_seq.
// master drives operands and result acceptance; slave is the divider.
interface fixed_div_seq_if #(
   parameter int N = 32,
   parameter int Q = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] quotient;
   logic         overflow;
   logic         div_by_zero;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, quotient, overflow, div_by_zero
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, quotient, overflow, div_by_zero
   );
endinterface

// File: rtl/fixed_div_seq.sv
// Sequential sign-magnitude fixed-point divider, restoring long division, one quotient bit per cycle.
// Define FIXED_DIV_ROUND_EN for one extra guard iteration and round-half-up of the quotient.
module fixed_div_seq #(
   parameter int N = 32,
   parameter int Q = 16
) (
   input logic           clk,
   input logic           reset,
   fixed_div_seq_if.slave bus
);
`ifdef FIXED_DIV_ROUND_EN
   localparam int ITERS = N + Q;
`else
   localparam int ITERS = N - 1 + Q;
`endif
   localparam int M  = N - 1;
   localparam int CW = $clog2(ITERS + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   // Dividend bits shift out of the MSB while quotient bits shift in at the LSB.
   logic [ITERS-1:0] dq, dq_nxt;
   logic [M-1:0]     rem, rem_nxt;
   logic [N-1:0]     rem_sh;
   logic [M-1:0]     div_mag;
   logic             sgn, dbz, ge;
   logic             accept, last;
   logic [M-1:0]     a_mag, b_mag;
   logic [M-1:0]     res_mag;
   logic             res_ovf, res_sgn;
   logic [N-1:0]     q_r;
   logic             ovf_r, dz_r;

   assign a_mag  = bus.a[M-1:0];
   assign b_mag  = bus.b[M-1:0];
   assign accept = bus.in_valid && bus.in_ready;
   assign last   = (state == BUSY) && (cnt == CW'(1));

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = BUSY;
         BUSY:    if (cnt == CW'(1)) state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // handshake outputs
   always_comb begin
      bus.in_ready  = (state == IDLE) && !reset;
      bus.out_valid = (state == DONE);
   end

   // one restoring step
   always_comb begin
      rem_sh  = {rem, dq[ITERS-1]};
      ge      = rem_sh >= {1'b0, div_mag};
      rem_nxt = ge ? M'(rem_sh - {1'b0, div_mag}) : rem_sh[M-1:0];
      dq_nxt  = {dq[ITERS-2:0], ge};
   end

   // result formatting from the final quotient word
`ifdef FIXED_DIV_ROUND_EN
   logic [M:0] rnd_sum;
   always_comb begin
      rnd_sum = {1'b0, dq_nxt[M:1]} + {{M{1'b0}}, dq_nxt[0]};
      res_ovf = (|dq_nxt[ITERS-1:M+1]) | rnd_sum[M];
      res_mag = res_ovf ? {M{1'b1}} : rnd_sum[M-1:0];
   end
`else
   always_comb begin
      res_ovf = |dq_nxt[ITERS-1:M];
      res_mag = res_ovf ? {M{1'b1}} : dq_nxt[M-1:0];
   end
`endif
   assign res_sgn = sgn & (res_mag != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         dq      <= '0;
         rem     <= '0;
         div_mag <= '0;
         sgn     <= 1'b0;
         dbz     <= 1'b0;
         q_r     <= '0;
         ovf_r   <= 1'b0;
         dz_r    <= 1'b0;
      end else if (accept) begin
         dq      <= {a_mag, {(ITERS-M){1'b0}}};
         rem     <= '0;
         div_mag <= b_mag;
         sgn     <= bus.a[N-1] ^ bus.b[N-1];
         dbz     <= (b_mag == '0);
         // A zero divisor skips the iterations and spends a single cycle in BUSY.
         cnt     <= (b_mag == '0) ? CW'(1) : CW'(ITERS);
      end else if (state == BUSY) begin
         dq  <= dq_nxt;
         rem <= rem_nxt;
         cnt <= cnt - CW'(1);
         if (last) begin
            if (dbz) begin
               q_r   <= {sgn, {M{1'b1}}};
               ovf_r <= 1'b0;
               dz_r  <= 1'b1;
            end else begin
               q_r   <= {res_sgn, res_mag};
               ovf_r <= res_ovf;
               dz_r  <= 1'b0;
            end
         end
      end
   end

   assign bus.quotient    = q_r;
   assign bus.overflow    = ovf_r;
   assign bus.div_by_zero = dz_r;
endmodule

// File: tb/tb_fixed_div_seq.sv
// Directed self-checking bench for fixed_div_seq: vector table plus back-pressure and reset-abort sequences.
module tb_fixed_div_seq;
   localparam int N = 32;
   localparam int Q = 16;
`ifdef FIXED_DIV_ROUND_EN
   localparam int ITERS = N + Q;
   localparam bit RND   = 1'b1;
`else
   localparam int ITERS = N - 1 + Q;
   localparam bit RND   = 1'b0;
`endif
   localparam int NV = 13;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q_trunc;
      logic [31:0] q_rnd;
      logic        ovf;
      logic        dz;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   fixed_div_seq_if #(.N(N), .Q(Q)) bus();
   fixed_div_seq #(.N(N), .Q(Q)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic ov, output logic dz, output int lat);
      int wait_cnt;
      wait_cnt = 0;
      @(negedge clk);
      while (!bus.in_ready && wait_cnt < 200) begin
         @(negedge clk);
         wait_cnt++;
      end
      check("in_ready_before_accept", bus.in_ready, 1);
      bus.a = a;
      bus.b = b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a = $urandom;
      bus.b = $urandom;
      lat = 0;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      q  = bus.quotient;
      ov = bus.overflow;
      dz = bus.div_by_zero;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("in_ready_after_handshake", bus.in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs [NV];
      logic [31:0] q;
      logic        ov, dz;
      int          lat, seen;

      vecs[0]  = '{"basic_3_over_1p5",   32'h0003_0000, 32'h0001_8000, 32'h0002_0000, 32'h0002_0000, 1'b0, 1'b0};
      vecs[1]  = '{"neg2_over_3",        32'h8002_0000, 32'h0003_0000, 32'h8000_AAAA, 32'h8000_AAAB, 1'b0, 1'b0};
      vecs[2]  = '{"div_by_neg_zero",    32'h0005_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1};
      vecs[3]  = '{"neg_zero_dividend",  32'h8000_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
      vecs[4]  = '{"overflow_big",       32'h4000_0000, 32'h0000_0100, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0};
      vecs[5]  = '{"one_third",          32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 32'h0000_5555, 1'b0, 1'b0};
      vecs[6]  = '{"7_over_neg2",        32'h0007_0000, 32'h8002_0000, 32'h8003_8000, 32'h8003_8000, 1'b0, 1'b0};
      vecs[7]  = '{"neg1_over_neg4",     32'h8001_0000, 32'h8004_0000, 32'h0000_4000, 32'h0000_4000, 1'b0, 1'b0};
      vecs[8]  = '{"tiny_neg_to_pzero",  32'h8000_0001, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
      vecs[9]  = '{"negzero_by_negzero", 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1};
      vecs[10] = '{"two_thirds",         32'h0002_0000, 32'h0003_0000, 32'h0000_AAAA, 32'h0000_AAAB, 1'b0, 1'b0};
      vecs[11] = '{"max_over_one",       32'h7FFF_FFFF, 32'h0001_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0};
      vecs[12] = '{"max_over_below_one", 32'h7FFF_FFFF, 32'h0000_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0};

      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_quotient", bus.quotient, 0);
      check("rst_overflow", bus.overflow, 0);
      check("rst_div_by_zero", bus.div_by_zero, 0);
      check("rst_in_ready", bus.in_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("in_ready_after_release", bus.in_ready, 1);

      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].a, vecs[i].b, q, ov, dz, lat);
         check({vecs[i].name, "_quotient"}, q, RND ? vecs[i].q_rnd : vecs[i].q_trunc);
         check({vecs[i].name, "_overflow"}, ov, vecs[i].ovf);
         check({vecs[i].name, "_div_by_zero"}, dz, vecs[i].dz);
         check({vecs[i].name, "_latency"}, lat, vecs[i].dz ? 1 : ITERS);
      end

      // back-pressure: result held while consumer stalls and inputs churn
      @(negedge clk);
      bus.a = 32'h0003_0000;
      bus.b = 32'h0001_8000;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("bp_latency", lat, ITERS);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         bus.in_valid = ~bus.in_valid;
         bus.a = $urandom;
         bus.b = $urandom;
         @(posedge clk);
         #1;
         check("bp_quotient", bus.quotient, 32'h0002_0000);
         check("bp_flags", {bus.overflow, bus.div_by_zero}, 2'b00);
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_in_ready", bus.in_ready, 0);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("bp_in_ready_after_hs", bus.in_ready, 1);
      check("bp_out_valid_after_hs", bus.out_valid, 0);
      run_op(32'h0001_0000, 32'h0000_8000, q, ov, dz, lat);
      check("bp_next_quotient", q, 32'h0002_0000);
      check("bp_next_latency", lat, ITERS);

      // reset during iteration 20 aborts the operation
      @(negedge clk);
      bus.a = 32'h0003_0000;
      bus.b = 32'h0001_8000;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rstmid_out_valid", bus.out_valid, 0);
      check("rstmid_quotient", bus.quotient, 32'h0002_0000 & 32'h0);
      check("rstmid_in_ready", bus.in_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen++;
      end
      check("rstmid_no_result", seen, 0);
      run_op(32'h0001_0000, 32'h0000_8000, q, ov, dz, lat);
      check("rstmid_after_quotient", q, 32'h0002_0000);
      check("rstmid_after_flags", {ov, dz}, 2'b00);
      check("rstmid_after_latency", lat, ITERS);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
